// File: rtl/alu32_server.sv
// alu32_server: request/response ALU server. One transaction in flight;
// logic/arithmetic ops finish in a fixed number of cycles, shifts run one bit
// per cycle. Optional feature: define ALU_SERVER_FLAGS_EN to add the
// rsp_flags = {ovf, neg, zero} output registered alongside rsp_z.
module alu32_server #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_x,
   input  logic [WIDTH-1:0] req_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_z,
   output logic             busy
`ifdef ALU_SERVER_FLAGS_EN
   ,
   output logic [2:0]       rsp_flags
`endif
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
   typedef enum logic [2:0] {
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_SRA
   } op_t;

   state_t           r_state;
   state_t           w_next_state;
   op_t              r_op;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_acc;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] w_result;
   logic             w_accept;
   logic             w_is_shift;
   logic             w_shifting;
   logic             w_exec_done;

   // Handshake and status decode. req_ready is gated by rst so it reads low
   // for the whole time reset is asserted, not just after the first edge.
   assign req_ready   = (r_state == S_IDLE) && !rst;
   assign rsp_valid   = (r_state == S_RESP);
   assign busy        = (r_state != S_IDLE);
   assign w_accept    = req_valid && req_ready;
   assign w_is_shift  = (r_op == OP_SLL) || (r_op == OP_SRA);
   assign w_shifting  = (r_state == S_EXEC) && w_is_shift && (r_cnt != '0);
   assign w_exec_done = (r_state == S_EXEC) && !w_shifting;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first, so no path through the case leaves the signal
      // unassigned and infers a latch.
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)    w_next_state = S_EXEC;
         S_EXEC:  if (w_exec_done) w_next_state = S_RESP;
         S_RESP:  if (rsp_ready)   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Result selection from registered operands; shifts report the accumulator.
   always_comb begin
      w_result = '0;
      case (r_op)
         OP_AND:  w_result = r_x & r_y;
         OP_OR:   w_result = r_x | r_y;
         OP_XOR:  w_result = r_x ^ r_y;
         OP_ADD:  w_result = r_x + r_y;
         OP_SUB:  w_result = r_x - r_y;
         OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(r_x) < $signed(r_y))};
         default: w_result = r_acc;
      endcase
   end

   // Operand capture, serial shifter and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op  <= OP_AND;
         r_x   <= '0;
         r_y   <= '0;
         r_acc <= '0;
         r_cnt <= '0;
         rsp_z <= '0;
      end else begin
         if (w_accept) begin
            r_op  <= op_t'(req_op);
            r_x   <= req_x;
            r_y   <= req_y;
            r_acc <= req_x;
            r_cnt <= req_y[SHW-1:0];
         end
         if (w_shifting) begin
            if (r_op == OP_SLL) r_acc <= {r_acc[WIDTH-2:0], 1'b0};
            else                r_acc <= {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            r_cnt <= r_cnt - SHW'(1);
         end
         if (w_exec_done) rsp_z <= w_result;
      end
   end

`ifdef ALU_SERVER_FLAGS_EN
   logic w_ovf;

   // Signed overflow: operands agree in sign (ADD) or differ (SUB), and the
   // result sign differs from x.
   always_comb begin
      w_ovf = 1'b0;
      case (r_op)
         OP_ADD:  w_ovf = (r_x[WIDTH-1] == r_y[WIDTH-1]) && (w_result[WIDTH-1] != r_x[WIDTH-1]);
         OP_SUB:  w_ovf = (r_x[WIDTH-1] != r_y[WIDTH-1]) && (w_result[WIDTH-1] != r_x[WIDTH-1]);
         default: w_ovf = 1'b0;
      endcase
   end

   // Flags register, loaded on the same edge as rsp_z.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              rsp_flags <= 3'b000;
      else if (w_exec_done) rsp_flags <= {w_ovf, w_result[WIDTH-1], (w_result == '0)};
   end
`endif

endmodule

// File: tb/tb_alu32_server.sv
// Testbench for alu32_server: directed cases, mid-shift reset and a random
// phase, with expected results queued at accept time and compared at response.
module tb_alu32_server;

   localparam int WIDTH = 32;

   typedef struct {
      logic [31:0] z;
      logic [2:0]  flags;
      int          edge_n;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_x = '0;
   logic [31:0] req_y = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_z;
   logic        busy;
`ifdef ALU_SERVER_FLAGS_EN
   logic [2:0]  rsp_flags;
`endif

   int checks = 0;
   int errors = 0;
   int accepted = 0;
   int responses = 0;
   int dropped = 0;
   exp_t sb[$];

   alu32_server #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_z     (rsp_z),
      .busy      (busy)
`ifdef ALU_SERVER_FLAGS_EN
      ,
      .rsp_flags (rsp_flags)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_z(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [4:0] sh;
      sh = y[4:0];
      case (op)
         3'd0: return x & y;
         3'd1: return x | y;
         3'd2: return x ^ y;
         3'd3: return x + y;
         3'd4: return x - y;
         3'd5: return {31'd0, ($signed(x) < $signed(y))};
         3'd6: return x << sh;
         default: return $signed(x) >>> sh;
      endcase
   endfunction

   function automatic logic [2:0] ref_flags(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] z;
      logic signed [32:0] wide;
      logic ovf;
      z = ref_z(op, x, y);
      ovf = 1'b0;
      if (op == 3'd3) begin
         wide = $signed({x[31], x}) + $signed({y[31], y});
         ovf = (wide > 33'sd2147483647) || (wide < -33'sd2147483648);
      end else if (op == 3'd4) begin
         wide = $signed({x[31], x}) - $signed({y[31], y});
         ovf = (wide > 33'sd2147483647) || (wide < -33'sd2147483648);
      end
      return {ovf, z[31], (z == 32'd0)};
   endfunction

   // Present a request, wait for acceptance, queue the expectation, then
   // scramble the request bus to show it is no longer sampled.
   task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input int idle);
      exp_t e;
      int n;
      repeat (idle) @(negedge clk);
      @(negedge clk);
      req_valid = 1'b1;
      req_op = op;
      req_x = x;
      req_y = y;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait_expired", 32'(n >= 50), 32'd0);
      e.z = ref_z(op, x, y);
      e.flags = ref_flags(op, x, y);
      e.edge_n = 2 + ((op == 3'd6 || op == 3'd7) ? int'(y[4:0]) : 0);
      sb.push_back(e);
      accepted++;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op = 3'($urandom);
      req_x = $urandom;
      req_y = $urandom;
   endtask

   // Wait for the response, check latency, hold it for 'hold' cycles with
   // rsp_ready low, then accept it and confirm the return to idle.
   task automatic recv(input int hold);
      exp_t e;
      int lat;
      logic [31:0] first_z;
      @(negedge clk);
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         rsp_ready = 1'($urandom);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      check("response_wait_expired", 32'(lat >= 100), 32'd0);
      check("scoreboard_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) e = sb.pop_front();
      check("response_edge", 32'(lat + 1), 32'(e.edge_n));
      check("rsp_z", rsp_z, e.z);
`ifdef ALU_SERVER_FLAGS_EN
      check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
`endif
      first_z = rsp_z;
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'($urandom);
         req_op = 3'($urandom);
         req_x = $urandom;
         req_y = $urandom;
         @(negedge clk);
         check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         check("hold_rsp_z", rsp_z, first_z);
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      responses++;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] x;
      logic [31:0] y;

      // Reset state while rst is high.
      #3;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_z", rsp_z, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Directed cases.
      send(3'd3, 32'h7FFF_FFFF, 32'h0000_0001, 0); recv(0);
`ifdef ALU_SERVER_FLAGS_EN
      check("add_ovf_flags_model", 32'(ref_flags(3'd3, 32'h7FFF_FFFF, 32'd1)), 32'b110);
`endif
      send(3'd0, 32'h1234_5678, 32'hFFFF_0000, 0); recv(5);
      send(3'd7, 32'h8000_0000, 32'd31, 1);        recv(0);
      send(3'd6, 32'h0000_0001, 32'h0000_0020, 0); recv(1);
      send(3'd6, 32'h0000_0001, 32'h0000_0021, 0); recv(0);
      send(3'd4, 32'h0000_0000, 32'h0000_0001, 0); recv(0);
      send(3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 0); recv(0);
      send(3'd5, 32'h0000_0001, 32'hFFFF_FFFF, 0); recv(0);
      send(3'd1, 32'hA5A5_0000, 32'h0000_5A5A, 0); recv(2);
      send(3'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 0); recv(0);
      send(3'd4, 32'h8000_0000, 32'h0000_0001, 0); recv(0);

      // Reset in the middle of an SLL-by-20 shift.
      send(3'd6, 32'h0000_0003, 32'd20, 0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_rsp_z", rsp_z, 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd0);
      sb.delete();
      dropped++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_release_req_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         check("midrst_no_response", 32'(rsp_valid), 32'd0);
      end
      send(3'd3, 32'd2, 32'd3, 0); recv(0);

      // Random phase.
      for (int i = 0; i < 500; i++) begin
         op = 3'($urandom);
         x = $urandom;
         y = $urandom;
         if (i % 8 == 0) x = 32'h8000_0000 | x;
         send(op, x, y, int'($urandom_range(0, 2)));
         recv(int'($urandom_range(0, 3)));
      end

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      check("response_count", 32'(responses), 32'(accepted - dropped));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
